i2s_audio_transmitter: RTL
==========================

Name: i2s_audio_transmitter

Overview:
- I2S bus master transmitter; the playback counterpart to the INMP441 microphone receiver.
- Accepts stereo PCM samples over a valid/ready handshake and generates SCK, WS and SD for an external I2S DAC (PCM5102 / MAX98357 class) on GPIO pins.
- Instantiated in board_specific_top next to the microphone receiver and clocked by the main board clock.
- Uses a 64-SCK frame: two 32-bit slots, data MSB-first, Philips I2S one-bit delay after each WS edge.

Parameters:
- sample_width, 24, bits per channel sample (1..31).
- sck_half_period, 8, clk cycles per SCK half period (>=2). At 50 MHz: SCK = 3.125 MHz, Fs = 48.828 kHz.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- left  input  sample_width  left sample, two's complement
- right  input  sample_width  right sample, two's complement
- valid  input  1  producer holds a sample pair
- ready  output  1  transmitter can accept a pair this cycle
- sck  output  1  I2S bit clock
- ws  output  1  word select: 0 = left slot, 1 = right slot
- sd  output  1  serial data
- underrun  output  1  one-cycle pulse: frame started with no new sample

Behaviour:
- Reset values, applied on the cycle rst is high: sck=0, ws=1, sd=0, ready=1, underrun=0, div counter=0, bit_cnt=63, holding empty, frame registers=0.
- Divider counts 0..sck_half_period-1. On terminal count it wraps to 0 and sck toggles.
  - sck_rise: toggle taking sck 0->1. DAC samples SD here.
  - sck_fall: toggle taking sck 1->0. All SD/WS updates happen here.
- First sck rise occurs sck_half_period cycles after reset deasserts; the first fall comes sck_half_period cycles later.
- On each sck_fall, bit_cnt increments mod 64 and ws/sd update in the same clk edge as sck:
  - ws = new bit_cnt[5].
  - Slot index k = new bit_cnt[4:0].
  - For 1 <= k <= sample_width: sd = slot_sample[sample_width-k], where slot_sample is frame_left when bit_cnt[5]=0, else frame_right.
  - Otherwise sd = 0. Slot bit 0 is the delay bit; trailing bits are zero padding.
- Frame load happens on the sck_fall where bit_cnt wraps 63->0:
  - Holding full: frame_left/right <= holding, holding becomes empty.
  - Holding empty and valid=1 in the same cycle: bypass; frame regs <= left/right directly, holding stays empty, ready stays 1 (handshake completes).
  - Holding empty and valid=0: frame regs keep their previous values (last pair repeats); underrun=1 for exactly that one clk cycle.
- Handshake:
  - ready = holding empty (registered state, no combinational path from valid).
  - Transfer when valid && ready. Outside the bypass case, the pair is captured into holding, which becomes full; ready drops on the next cycle.
  - valid with ready=0 has no effect; the producer must hold.
- Buffering depth: one pair in frame regs plus one in holding. Sustained rate is one pair per 64 SCK.
- Reset mid-frame: the frame is abandoned immediately and outputs return to reset values; holding contents are lost.
- sck duty is exactly 50%. SCK period = 2*sck_half_period clk cycles; frame = 128*sck_half_period clk cycles.

Test Plan:
- Reset, then hold valid=0, sck_half_period=2 -> sck toggles every 2 cycles; first fall at cycle 4 sets ws=0; sd=0 throughout; underrun pulses once per frame, every 256 cycles.
- Reset, then present left=24'hA50001, right=24'h800000 with valid=1 before the first frame load -> bypass accepted. Left slot: bits 1..24 on SD at sck rises read A50001 MSB-first. Right slot: bit 33 is 1, bits 34..56 are 0. Padding bits are 0. ws is 0 for 32 SCK, then 1 for 32 SCK.
- Stream 4 distinct pairs with valid held high -> each frame carries the next pair in order; ready is low while holding is full; no underrun.
- Send one pair, then stop -> the following frames repeat that pair, with underrun pulsing at each of their loads.
- Assert rst at bit_cnt=40 -> next cycle sck=0, ws=1, sd=0, ready=1. The following frame starts from bit 0 with zero data and underrun.
- sample_width=16, left=16'hFFFF -> sd=1 exactly for left-slot bits 1..16 and 0 for bits 17..31.

Source files
------------

// File: rtl/i2s_audio_transmitter.sv
// I2S master transmitter: 64-SCK Philips frames (two 32-bit slots, MSB-first,
// one-bit delay) fed by a valid/ready stereo sample interface with one-pair holding buffer.
module i2s_audio_transmitter #(
  parameter int sample_width    = 24,
  parameter int sck_half_period = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [sample_width-1:0] left,
  input  logic signed [sample_width-1:0] right,
  input  logic                           valid,
  output logic                           ready,
  output logic                           sck,
  output logic                           ws,
  output logic                           sd,
  output logic                           underrun
);

  localparam int DIV_W = $clog2(sck_half_period);
  localparam int IDX_W = (sample_width > 1) ? $clog2(sample_width) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(sck_half_period - 1);

  logic [DIV_W-1:0]               div_cnt;
  logic [5:0]                     bit_cnt;
  logic [5:0]                     bit_next;
  logic                           hold_full;
  logic signed [sample_width-1:0] hold_left;
  logic signed [sample_width-1:0] hold_right;
  logic signed [sample_width-1:0] frame_left;
  logic signed [sample_width-1:0] frame_right;
  logic                           sck_toggle;
  logic                           sck_fall;
  logic                           frame_load;
  logic                           capture;

  // Slot bit k carries sample[sample_width-k]; bit 0 is the delay bit, the tail is padding.
  function automatic logic slot_bit(input logic signed [sample_width-1:0] sample,
                                    input logic [4:0] k);
    logic [IDX_W-1:0] idx;
    slot_bit = 1'b0;
    if (k != 5'd0 && int'(k) <= sample_width) begin
      idx      = IDX_W'(sample_width - int'(k));
      slot_bit = sample[idx];
    end
  endfunction

  assign ready      = ~hold_full;
  assign sck_toggle = (div_cnt == DIV_LAST);
  assign sck_fall   = sck_toggle & sck;
  assign bit_next   = bit_cnt + 6'd1;
  assign frame_load = sck_fall && (bit_cnt == 6'd63);
  assign capture    = valid && !hold_full && !frame_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      sck         <= 1'b0;
      ws          <= 1'b1;
      sd          <= 1'b0;
      underrun    <= 1'b0;
      bit_cnt     <= 6'd63;
      hold_full   <= 1'b0;
      frame_left  <= '0;
      frame_right <= '0;
    end else begin
      underrun <= 1'b0;
      if (sck_toggle) begin
        div_cnt <= '0;
        sck     <= ~sck;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (sck_fall) begin
        bit_cnt <= bit_next;
        ws      <= bit_next[5];
        sd      <= slot_bit(bit_next[5] ? frame_right : frame_left, bit_next[4:0]);
      end

      // An empty holding buffer at load time takes the producer's pair directly.
      if (frame_load) begin
        if (hold_full) begin
          frame_left  <= hold_left;
          frame_right <= hold_right;
          hold_full   <= 1'b0;
        end else if (valid) begin
          frame_left  <= left;
          frame_right <= right;
        end else begin
          underrun <= 1'b1;
        end
      end else if (capture) begin
        hold_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      hold_left  <= left;
      hold_right <= right;
    end
  end

endmodule
